// File: rtl/jk_bank_driver.sv
// Drives an external bank of JK flip-flops toward a requested word, then checks the result and
// retries on mismatch. Optional macro JK_BANK_DRIVER_TOGGLE_EN selects J1K1 toggle drive.
module jk_bank_driver #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             done,
  output logic             pass,
  output logic             err
);

  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);
  localparam logic [RetryW-1:0] RetryOne = RetryW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StApply,
    StSettle,
    StCheck
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   tgt_q, tgt_d;
  logic [RetryW-1:0]  retry_q, retry_d;
  logic               err_q, err_d;

  logic               match;
  logic [WIDTH-1:0]   j_apply;
  logic [WIDTH-1:0]   k_apply;

  assign match = (q_fb == tgt_q);

`ifdef JK_BANK_DRIVER_TOGGLE_EN
  // Only differing bits need to move; toggling them reaches the target from either side.
  assign j_apply = q_fb ^ tgt_q;
  assign k_apply = q_fb ^ tgt_q;
`else
  assign j_apply = ~q_fb & tgt_q;
  assign k_apply = q_fb & ~tgt_q;
`endif

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    retry_d   = retry_q;
    err_d     = err_q;
    tgt_ready = 1'b0;
    j         = '0;
    k         = '0;
    done      = 1'b0;
    pass      = 1'b0;

    unique case (state_q)
      StIdle: begin
        tgt_ready = 1'b1;
        if (tgt_valid) begin
          tgt_d   = tgt_data;
          retry_d = '0;
          state_d = StApply;
        end
      end
      StApply: begin
        j       = j_apply;
        k       = k_apply;
        state_d = StSettle;
      end
      StSettle: begin
        state_d = StCheck;
      end
      StCheck: begin
        if (match) begin
          done    = 1'b1;
          pass    = 1'b1;
          state_d = StIdle;
        end else if (retry_q < RetryMax) begin
          err_d   = 1'b1;
          retry_d = retry_q + RetryOne;
          state_d = StApply;
        end else begin
          err_d   = 1'b1;
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      tgt_q   <= '0;
      retry_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      retry_q <= retry_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;

`ifndef SYNTHESIS
  a_drive_only_in_apply: assert property (@(posedge clk) disable iff (!reset_n)
    (state_q != StApply) |-> (j == '0 && k == '0));
  a_pass_needs_done: assert property (@(posedge clk) disable iff (!reset_n)
    pass |-> done);
`ifndef JK_BANK_DRIVER_TOGGLE_EN
  a_no_toggle_drive: assert property (@(posedge clk) disable iff (!reset_n)
    (j & k) == '0);
`endif
`endif

endmodule
